multicycle_ctrl: RTL

//  Main control FSM for the multi-cycle RV32I core. Sequences each instruction through

---
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback, drives datapath mux selects and
// enables, handshakes with memory via MemReq/mem_ready, counts retired instructions
// and traps (sticky) on illegal opcodes, illegal branch funct3 or memory timeouts.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [2:0]           ImmSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ResultSrc,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I    = 3'b000;
    localparam logic [2:0] IMM_S    = 3'b001;
    localparam logic [2:0] IMM_B    = 3'b010;
    localparam logic [2:0] IMM_U    = 3'b011;
    localparam logic [2:0] IMM_JAL  = 3'b100;
    localparam logic [2:0] IMM_JALR = 3'b101;

    // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t               state, state_n;
    logic [WW-1:0]        wait_cnt;
    logic                 trap_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 timeout;
    logic                 br_taken, br_illegal;

    // A stalled memory state times out on the cycle that would reach MEM_TIMEOUT waits.
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

    // Branch condition resolve from ALU flags; funct3 010/011 are not branches.
    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = !lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = !ltu;
            default: br_illegal = 1'b1;
        endcase
    end

    // State, wait counter, sticky trap and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)
                wait_cnt <= '0;
            else if (MemReq && !mem_ready)
                wait_cnt <= wait_cnt + WW'(1);
            if (state_n == TRAP)
                trap_q <= 1'b1;
            if (state_n == FETCH && state != FETCH)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Next-state and control decode; everything held low during reset.
    always_comb begin
        state_n   = state;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ImmSrc    = IMM_I;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        ResultSrc = 2'b00;
        if (!rst) begin
            case (state)
                FETCH: begin
                    MemReq = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        state_n = DECODE;
                    end else if (timeout) begin
                        state_n = TRAP;
                    end
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_B;
                    case (op)
                        OP_LOAD, OP_STORE: state_n = MEMADR;
                        OP_R:              state_n = EXEC_R;
                        OP_I:              state_n = EXEC_I;
                        OP_BRANCH:         state_n = BRANCH;
                        OP_JAL:            state_n = JAL;
                        OP_JALR:           state_n = JALR;
                        OP_LUI:            state_n = LUI;
                        OP_AUIPC:          state_n = AUIPC;
                        default:           state_n = TRAP;
                    endcase
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                    state_n = (op == OP_STORE) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    if (mem_ready)    state_n = MEMWB;
                    else if (timeout) state_n = TRAP;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                    state_n   = FETCH;
                end
                MEMWR: begin
                    MemReq   = 1'b1;
                    MemWrite = 1'b1;
                    AdrSrc   = 1'b1;
                    if (mem_ready)    state_n = FETCH;
                    else if (timeout) state_n = TRAP;
                end
                EXEC_R: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b00;
                    ALUOp   = 2'b10;
                    state_n = ALUWB;
                end
                EXEC_I: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_I;
                    ALUOp   = 2'b10;
                    state_n = ALUWB;
                end
                ALUWB: begin
                    ResultSrc = 2'b00;
                    RegWrite  = 1'b1;
                    state_n   = FETCH;
                end
                BRANCH: begin
                    ALUSrcA   = 2'b10;
                    ALUSrcB   = 2'b00;
                    ALUOp     = 2'b01;
                    ResultSrc = 2'b00;
                    PCWrite   = br_taken;
                    state_n   = br_illegal ? TRAP : FETCH;
                end
                JAL: begin
                    ImmSrc   = IMM_JAL;
                    ALUSrcA  = 2'b01;
                    ALUSrcB  = 2'b10;
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    state_n  = FETCH;
                end
                JALR: begin
                    ImmSrc   = IMM_JALR;
                    ALUSrcA  = 2'b10;
                    ALUSrcB  = 2'b01;
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    state_n  = FETCH;
                end
                LUI: begin
                    ImmSrc    = IMM_U;
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                    state_n   = FETCH;
                end
                AUIPC: begin
                    ImmSrc    = IMM_U;
                    ALUSrcA   = 2'b01;
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    RegWrite  = 1'b1;
                    state_n   = FETCH;
                end
                TRAP:    state_n = TRAP;
                default: state_n = TRAP;
            endcase
        end
    end

    assign trap    = trap_q & ~rst;
    assign instret = rst ? '0 : cnt_q;

endmodule
